dds_tone_sched: RTL and testbench
=================================

// Module: dds_tone_sched
// PURPOSE
//   Symbol-rate tone scheduler for the DDS phase accumulator (FSK/WSPR-style keying).
//   Buffers symbols from the upstream message source in a small FIFO.
//   Converts each symbol to a frequency word and holds it for a programmed clock count.
//   Drives the accumulator's FWORD/PWORD inputs and the transmitter keying enable.
// PARAMETERS
//   SYM_W   2   symbol width in bits; tone index 0..2^SYM_W-1
//   DEPTH   16  symbol FIFO depth; power of 2, >= 2
//   DUR_W   24  width of the symbol-duration counter
// PORTS
//   clk          in   1       system clock
//   rst_n        in   1       asynchronous active-low reset
//   cfg_base     in   32      frequency word of tone 0
//   cfg_step     in   32      frequency-word spacing between adjacent tones
//   cfg_dur      in   DUR_W   symbol length in clk cycles; 0 treated as 1
//   cfg_pword    in   16      phase word passed to the accumulator
//   start        in   1       1-cycle pulse: begin transmission
//   abort        in   1       1-cycle pulse: stop immediately, flush FIFO
//   sym_data     in   SYM_W   symbol to enqueue
//   sym_valid    in   1       sym_data valid
//   sym_ready    out  1       FIFO can accept; a transfer is sym_valid & sym_ready
//   FWORD        out  32      frequency word to the accumulator
//   PWORD        out  16      phase word to the accumulator
//   tx_en        out  1       high while a tone is being transmitted
//   sym_strobe   out  1       1-cycle pulse on the first cycle of each symbol
//   done         out  1       1-cycle pulse when transmission ends normally
//   fifo_level   out  clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//   Reset: FIFO empty, state IDLE; FWORD=0, PWORD=0, tx_en=0, sym_strobe=0, done=0.
//   Reset: sym_ready=1, fifo_level=0. Reset asserted mid-symbol aborts at once; no done pulse.
//   FIFO: sym_ready = !full. Push when sym_valid & sym_ready; pops happen only in FSM.
//   FIFO: push and pop in the same cycle both take effect; level is unchanged.
//   Config latch: cfg_base/step/dur/pword are captured on the accepted start.
//   Config latch: changes during a transmission have no effect until the next start.
//   Tone word: FWORD = base + sym*step, modulo 2^32; overflow wraps silently.
//   FSM IDLE: start & !empty -> pop, load FWORD, cnt=dur-1, tx_en=1, sym_strobe=1 -> RUN.
//   FSM IDLE: all outputs change on the cycle after start. start with FIFO empty is ignored.
//   FSM RUN: cnt!=0 -> cnt-1. cnt==0 & !empty -> pop, load next FWORD, cnt=dur-1, strobe.
//   FSM RUN: symbol boundaries have no gap; every symbol's FWORD is held exactly dur cycles.
//   FSM RUN: cnt==0 & empty -> END (see CONFIGURATION).
//   FSM RUN: start while in RUN is ignored.
//   END: FWORD=0, tx_en=0, done=1 for one cycle -> IDLE.
//   PWORD holds the latched cfg_pword while tx_en=1; it is 0 otherwise.
//   abort (any state, highest priority): flush FIFO, FWORD=0, tx_en=0 next cycle -> IDLE.
//   abort: no done pulse. A push in the abort cycle is discarded.
// CONFIGURATION
//   Macro TONE_SCHED_UNDERRUN_HOLD_EN. When undefined, an empty FIFO at a symbol boundary
//   ends the message normally (END, done pulse).
//   When defined:
//     - Add input msg_last (1b). An empty FIFO at a boundary holds the last FWORD
//       (tx_en stays 1) until a symbol arrives, and sets a sticky output underrun.
//     - underrun is cleared by the next accepted start or by reset.
//     - A symbol that arrives during the hold is loaded on the following cycle,
//       with a sym_strobe pulse.
//     - END is entered only when msg_last=1 at an empty boundary.
// TESTING
//   1 Reset, then push 3,1,0 (base=1000, step=10, dur=4), then start. Required:
//     FWORD=1030 for cycles 1-4, 1010 for cycles 5-8, 1000 for cycles 9-12;
//     sym_strobe at cycles 1, 5 and 9; done at cycle 13; tx_en low from cycle 13.
//   2 Push 17 symbols with DEPTH=16 and no start. Required: sym_ready=0 after the 16th
//     push, the 17th is not accepted, fifo_level=16.
//   3 dur=0 with 2 symbols queued. Required: each FWORD is held 1 cycle and done follows.
//   4 base=32'hFFFF_FFF0, step=32'h20, symbol 1. Required: FWORD=32'h0000_0010 (wrap).
//   5 abort in the middle of symbol 2 of 5. Required: next cycle tx_en=0, FWORD=0,
//     fifo_level=0; no done pulse; a later start with an empty FIFO is ignored.
//   6 With TONE_SCHED_UNDERRUN_HOLD_EN defined: starve the FIFO after symbol 1. Required:
//     FWORD held, underrun=1. Push a symbol: loaded with strobe. msg_last=1: done pulse.

Source files
------------

// File: rtl/dds_tone_sched.sv
// dds_tone_sched: FIFO-fed symbol-to-tone scheduler driving DDS FWORD/PWORD and keying enable.
// Optional underrun hold with msg_last/underrun ports: define TONE_SCHED_UNDERRUN_HOLD_EN.
module dds_tone_sched #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 16,
  parameter int DUR_W = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              cfg_base,
  input  logic [31:0]              cfg_step,
  input  logic [DUR_W-1:0]         cfg_dur,
  input  logic [15:0]              cfg_pword,
  input  logic                     start,
  input  logic                     abort,
  input  logic [SYM_W-1:0]         sym_data,
  input  logic                     sym_valid,
  output logic                     sym_ready,
  output logic [31:0]              FWORD,
  output logic [15:0]              PWORD,
  output logic                     tx_en,
  output logic                     sym_strobe,
  output logic                     done,
`ifdef TONE_SCHED_UNDERRUN_HOLD_EN
  input  logic                     msg_last,
  output logic                     underrun,
`endif
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, END} state_t;
  state_t state, state_n;
  logic [SYM_W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] base_r, step_r, fword_n, tone, base_sel, step_sel;
  logic [DUR_W-1:0] dur_r, cnt, cnt_n, dur_sel, cnt_ld;
  logic [15:0] pword_r;
  logic empty, push, pop, latch, tx_n, strobe_n, done_n;
`ifdef TONE_SCHED_UNDERRUN_HOLD_EN
  logic und_n;
`endif
  assign fifo_level = wr_ptr - rd_ptr;
  assign empty = fifo_level == '0;
  assign sym_ready = fifo_level != (AW+1)'(DEPTH);
  assign push = sym_valid && sym_ready && !abort;
  assign PWORD = tx_en ? pword_r : 16'd0;
  // The first symbol uses the live config, since it is latched on that same edge.
  assign base_sel = state == IDLE ? cfg_base : base_r;
  assign step_sel = state == IDLE ? cfg_step : step_r;
  assign dur_sel = state == IDLE ? cfg_dur : dur_r;
  assign cnt_ld = dur_sel == '0 ? '0 : dur_sel - DUR_W'(1);
  assign tone = base_sel + 32'(mem[rd_ptr[AW-1:0]]) * step_sel;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= sym_data;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    fword_n = FWORD;
    tx_n = tx_en;
    strobe_n = 1'b0;
    done_n = 1'b0;
    pop = 1'b0;
    latch = 1'b0;
`ifdef TONE_SCHED_UNDERRUN_HOLD_EN
    und_n = underrun;
`endif
    if (abort) begin
      state_n = IDLE;
      fword_n = '0;
      tx_n = 1'b0;
    end else if ((state == IDLE && start && !empty) || (state == RUN && cnt == '0 && !empty)) begin
      latch = state == IDLE;
      pop = 1'b1;
      state_n = RUN;
      fword_n = tone;
      cnt_n = cnt_ld;
      tx_n = 1'b1;
      strobe_n = 1'b1;
`ifdef TONE_SCHED_UNDERRUN_HOLD_EN
      und_n = latch ? 1'b0 : underrun;
`endif
    end else if (state == RUN && cnt != '0) begin
      cnt_n = cnt - DUR_W'(1);
`ifdef TONE_SCHED_UNDERRUN_HOLD_EN
    end else if (state == RUN && !msg_last) begin
      und_n = 1'b1;
`endif
    end else if (state == RUN) begin
      state_n = END;
      fword_n = '0;
      tx_n = 1'b0;
      done_n = 1'b1;
    end else if (state == END) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      FWORD <= '0;
      tx_en <= 1'b0;
      sym_strobe <= 1'b0;
      done <= 1'b0;
      base_r <= '0;
      step_r <= '0;
      dur_r <= '0;
      pword_r <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
`ifdef TONE_SCHED_UNDERRUN_HOLD_EN
      underrun <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      FWORD <= fword_n;
      tx_en <= tx_n;
      sym_strobe <= strobe_n;
      done <= done_n;
      wr_ptr <= abort ? '0 : wr_ptr + (AW+1)'(push);
      rd_ptr <= abort ? '0 : rd_ptr + (AW+1)'(pop);
`ifdef TONE_SCHED_UNDERRUN_HOLD_EN
      underrun <= und_n;
`endif
      if (latch) begin
        base_r <= cfg_base;
        step_r <= cfg_step;
        dur_r <= cfg_dur;
        pword_r <= cfg_pword;
      end
    end
  end
endmodule

// File: tb/tb_dds_tone_sched.sv
// tb_dds_tone_sched: scoreboard bench; stimulus queues expected tone cycles, a monitor checks them.
module tb_dds_tone_sched;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, sym_valid = 0;
  logic [31:0] cfg_base = 0, cfg_step = 0;
  logic [23:0] cfg_dur = 0;
  logic [15:0] cfg_pword = 0;
  logic [1:0] sym_data = 0;
  logic sym_ready, tx_en, sym_strobe, done;
  logic [31:0] FWORD;
  logic [15:0] PWORD;
  logic [4:0] fifo_level;
`ifdef TONE_SCHED_UNDERRUN_HOLD_EN
  logic msg_last = 1, underrun;
`endif
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] fw; logic [15:0] pw; logic st, dn, tx;} exp_t;
  exp_t q[$];

  dds_tone_sched dut (
    .clk(clk), .rst_n(rst_n), .cfg_base(cfg_base), .cfg_step(cfg_step), .cfg_dur(cfg_dur),
    .cfg_pword(cfg_pword), .start(start), .abort(abort), .sym_data(sym_data), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .FWORD(FWORD), .PWORD(PWORD), .tx_en(tx_en), .sym_strobe(sym_strobe),
    .done(done),
`ifdef TONE_SCHED_UNDERRUN_HOLD_EN
    .msg_last(msg_last), .underrun(underrun),
`endif
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sym(logic [1:0] s);
    sym_data = s;
    sym_valid = 1;
    tick();
    sym_valid = 0;
  endtask

  task automatic start_tx();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic exp_sym(logic [31:0] fw, logic [15:0] pw, int n, bit strobe_first);
    for (int i = 0; i < n; i++) q.push_back('{fw, pw, strobe_first && i == 0, 1'b0, 1'b1});
  endtask

  task automatic exp_done();
    q.push_back('{32'd0, 16'd0, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic drain(string n);
    for (int i = 0; i < 200 && q.size() != 0; i++) tick();
    check(n, q.size(), 0);
    q.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (tx_en || done)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: FWORD=%0h tx_en=%0b done=%0b expected idle", FWORD, tx_en, done);
      end else begin
        e = q.pop_front();
        check("FWORD", FWORD, e.fw);
        check("PWORD", 32'(PWORD), 32'(e.pw));
        check("sym_strobe", 32'(sym_strobe), 32'(e.st));
        check("done", 32'(done), 32'(e.dn));
        check("tx_en", 32'(tx_en), 32'(e.tx));
      end
    end
  end

  initial begin
    repeat (3) tick();
    check("rst_FWORD", FWORD, 0);
    check("rst_PWORD", 32'(PWORD), 0);
    check("rst_tx_en", 32'(tx_en), 0);
    check("rst_strobe", 32'(sym_strobe), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ready", 32'(sym_ready), 1);
    check("rst_level", 32'(fifo_level), 0);
    rst_n = 1;
    tick();
    // message 3,1,0 with config changes after start that must be ignored
    cfg_base = 1000; cfg_step = 10; cfg_dur = 4; cfg_pword = 16'h1234;
    push_sym(3); push_sym(1); push_sym(0);
    check("t1_level", 32'(fifo_level), 3);
    exp_sym(1030, 16'h1234, 4, 1); exp_sym(1010, 16'h1234, 4, 1); exp_sym(1000, 16'h1234, 4, 1);
    exp_done();
    start_tx();
    cfg_base = 5000; cfg_step = 1; cfg_dur = 1; cfg_pword = 0;
    drain("t1_drain");
    check("t1_tx_low", 32'(tx_en), 0);
    check("t1_level_end", 32'(fifo_level), 0);
    // FIFO fill: 17th push refused
    for (int i = 0; i < 16; i++) push_sym(2'(i));
    check("t2_level16", 32'(fifo_level), 16);
    check("t2_ready0", 32'(sym_ready), 0);
    push_sym(3);
    check("t2_level_17th", 32'(fifo_level), 16);
    abort = 1;
    tick();
    abort = 0;
    check("t2_flush_level", 32'(fifo_level), 0);
    check("t2_flush_ready", 32'(sym_ready), 1);
    // dur=0 acts as 1
    cfg_base = 1000; cfg_step = 10; cfg_dur = 0; cfg_pword = 16'h00AA;
    push_sym(2); push_sym(1);
    exp_sym(1020, 16'h00AA, 1, 1); exp_sym(1010, 16'h00AA, 1, 1); exp_done();
    start_tx();
    drain("t3_drain");
    // 32-bit wrap of base + sym*step
    cfg_base = 32'hFFFF_FFF0; cfg_step = 32'h20; cfg_dur = 2; cfg_pword = 16'h0001;
    push_sym(1);
    exp_sym(32'h0000_0010, 16'h0001, 2, 1); exp_done();
    start_tx();
    drain("t4_drain");
    // abort mid symbol 2 of 5, with a push in the abort cycle
    cfg_base = 100; cfg_step = 1; cfg_dur = 4; cfg_pword = 16'h0055;
    push_sym(0); push_sym(1); push_sym(2); push_sym(3); push_sym(1);
    exp_sym(100, 16'h0055, 4, 1); exp_sym(101, 16'h0055, 2, 1);
    start_tx();
    repeat (5) tick();
    abort = 1; sym_valid = 1; sym_data = 3;
    tick();
    abort = 0; sym_valid = 0;
    check("t5_consumed", q.size(), 0);
    check("t5_tx_en", 32'(tx_en), 0);
    check("t5_FWORD", FWORD, 0);
    check("t5_done", 32'(done), 0);
    check("t5_level", 32'(fifo_level), 0);
    start_tx();
    repeat (3) tick();
    check("t5_start_empty", 32'(tx_en), 0);
`ifdef TONE_SCHED_UNDERRUN_HOLD_EN
    // underrun hold: starve after symbol 1, then resume and end with msg_last
    cfg_base = 500; cfg_step = 5; cfg_dur = 2; cfg_pword = 16'h0777; msg_last = 0;
    push_sym(1);
    exp_sym(505, 16'h0777, 5, 1); exp_sym(515, 16'h0777, 2, 1); exp_done();
    start_tx();
    repeat (2) tick();
    check("t6_underrun", 32'(underrun), 1);
    tick();
    push_sym(3);
    msg_last = 1;
    drain("t6_drain");
    check("t6_underrun_sticky", 32'(underrun), 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
